match_ctrl: RTL and testbench
=============================

MATCH_CTRL -- requirements
Module: match_ctrl

Interface
REQ-001 SHALL have parameter SERVE_FRAMES, default 60, frames the ball is held at centre before each serve.
REQ-002 SHALL have parameter WIN_SCORE, default 11, points that end a match (range 1..99).
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port frame_tick  input  1  one-cycle pulse per video frame.
REQ-006 SHALL have port start  input  1  player start button, level, synchronised upstream.
REQ-007 SHALL have port goal_left  input  1  one-cycle pulse: ball passed left boundary (right player scores).
REQ-008 SHALL have port goal_right  input  1  one-cycle pulse: ball passed right boundary (left player scores).
REQ-009 SHALL have port ball_run  output  1  ball motion enable.
REQ-010 SHALL have port ball_recentre  output  1  one-cycle pulse commanding ball to centre with new random dy.
REQ-011 SHALL have port serve_dir  output  1  serve direction (0 = toward left, 1 = toward right).
REQ-012 SHALL have ports score_l_tens, score_l_ones, score_r_tens, score_r_ones  output  4 each  BCD scores.
REQ-013 SHALL have port winner  output  2  00 none, 01 left, 10 right.
REQ-014 SHALL have port state_o  output  3  current state encoding, for debug LEDs.

Function
REQ-015 SHALL implement states IDLE, SERVE, RALLY, POINT, OVER.
REQ-016 IDLE: ball_run=0; start=1 SHALL clear both scores, pulse ball_recentre, enter SERVE.
REQ-017 SERVE: ball_run=0; frame counter SHALL count frame_tick pulses; on SERVE_FRAMES-th tick SHALL enter RALLY next cycle.
REQ-018 RALLY: ball_run=1; single goal pulse SHALL register scorer and enter POINT; no goal keeps RALLY.
REQ-019 goal_left and goal_right asserted in the same cycle SHALL award no point, pulse ball_recentre, re-enter SERVE (let).
REQ-020 Goal pulses outside RALLY SHALL be ignored.
REQ-021 POINT (exactly one cycle): scorer's BCD score SHALL increment (ones 9 -> 0 with tens+1); saturate at 99.
REQ-022 After POINT, if win condition met SHALL enter OVER, else pulse ball_recentre and enter SERVE.
REQ-023 serve_dir SHALL be set in POINT toward the player who conceded (left scores -> 1, right scores -> 0); initial value 0.
REQ-024 Win condition (default): scorer's score equals WIN_SCORE.
REQ-025 OVER: ball_run=0, winner held; start SHALL act as in IDLE (new match, winner cleared).
REQ-026 ball_run SHALL be registered, asserted the cycle after entering RALLY, deasserted the cycle after a goal pulse.
REQ-027 Score compare SHALL convert BCD to binary (tens*10+ones, 7 bits); no other arithmetic wider than 7 bits.

Reset
REQ-028 reset SHALL force state IDLE, all scores 0, winner 00, serve_dir 0, ball_run 0, ball_recentre 0, frame counter 0, independent of clk.
REQ-029 reset asserted mid-RALLY or mid-SERVE SHALL abandon the point without score change.

Configuration
REQ-030 Macro MATCH_WIN_BY_TWO_EN defined: win requires scorer >= WIN_SCORE and lead >= 2; OVER also reached if scorer reaches 99.
REQ-031 Macro MATCH_WIN_BY_TWO_EN undefined: REQ-024 rule only; lead logic absent from netlist.

Structure
REQ-032 Shared package pong_pkg SHALL hold state enum, winner encodings, default SERVE_FRAMES and WIN_SCORE constants.
REQ-033 Two-digit saturating BCD counter SHALL be sub-module bcd_counter2, instantiated once per player.

Verification
REQ-034 Reset then start=1, SERVE_FRAMES=60: ball_recentre pulse, ball_run rises exactly one cycle after 60th frame_tick.
REQ-035 In RALLY, goal_right pulse at left=0:9: left score 1:0, serve_dir=1, ball_recentre pulse, state SERVE.
REQ-036 goal_left and goal_right same cycle at 3:4: scores unchanged, state SERVE.
REQ-037 WIN_SCORE=11, left 10 right 9, goal_right: winner=01, state OVER, further goals ignored; with MATCH_WIN_BY_TWO_EN, left 10 right 10 -> 11:10 stays in play, 12:10 -> winner=01.
REQ-038 reset asserted mid-RALLY at score 5:5: all outputs return to reset values asynchronously, state IDLE.

Source files
------------

// File: rtl/pong_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pong_pkg : shared match-controller types, encodings and defaults |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_RALLY = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam logic [1:0] c_winner_none  = 2'b00;
  localparam logic [1:0] c_winner_left  = 2'b01;
  localparam logic [1:0] c_winner_right = 2'b10;

  localparam int c_serve_frames_def = 60;
  localparam int c_win_score_def    = 11;

  // Two BCD digits to a 7-bit binary value (0..99 for valid BCD).
  function automatic logic [6:0] bcd_to_bin(input logic [3:0] tens, input logic [3:0] ones);
    bcd_to_bin = (7'(tens) * 7'd10) + 7'(ones);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_counter2.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bcd_counter2 : two-digit BCD counter, saturating at 99           |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module bcd_counter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_clear,
  input  logic       i_inc,
  output logic [3:0] o_tens,
  output logic [3:0] o_ones,
  output logic [3:0] o_nxt_tens,
  output logic [3:0] o_nxt_ones
);

  logic [3:0] r_tens;
  logic [3:0] r_ones;
  logic [3:0] w_nxt_tens;
  logic [3:0] w_nxt_ones;

  // Value after one increment; exposed so the owner can judge the result early.
  always_comb begin
    w_nxt_tens = r_tens;
    w_nxt_ones = r_ones;
    if (!((r_tens == 4'd9) && (r_ones == 4'd9))) begin
      if (r_ones == 4'd9) begin
        w_nxt_ones = 4'd0;
        w_nxt_tens = r_tens + 4'd1;
      end else begin
        w_nxt_ones = r_ones + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tens <= 4'd0;
      r_ones <= 4'd0;
    end else if (i_clear) begin
      r_tens <= 4'd0;
      r_ones <= 4'd0;
    end else if (i_inc) begin
      r_tens <= w_nxt_tens;
      r_ones <= w_nxt_ones;
    end
  end

  assign o_tens     = r_tens;
  assign o_ones     = r_ones;
  assign o_nxt_tens = w_nxt_tens;
  assign o_nxt_ones = w_nxt_ones;

endmodule
`default_nettype wire

// File: rtl/match_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | match_ctrl : pong match sequencing, scoring and win detection    |
// | Option macro MATCH_WIN_BY_TWO_EN : win needs a two-point lead    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module match_ctrl
  import pong_pkg::*;
#(
  parameter int SERVE_FRAMES = c_serve_frames_def,
  parameter int WIN_SCORE    = c_win_score_def
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       goal_left,
  input  logic       goal_right,
  output logic       ball_run,
  output logic       ball_recentre,
  output logic       serve_dir,
  output logic [3:0] score_l_tens,
  output logic [3:0] score_l_ones,
  output logic [3:0] score_r_tens,
  output logic [3:0] score_r_ones,
  output logic [1:0] winner,
  output logic [2:0] state_o
);

  localparam int               c_cnt_w     = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
  localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(SERVE_FRAMES - 1);
  localparam logic [6:0]       c_win_score = 7'(WIN_SCORE);

  state_t             r_state;
  state_t             w_next_state;
  logic [c_cnt_w-1:0] r_frame_cnt;
  logic               r_scorer_left;
  logic               r_ball_run;
  logic               r_ball_recentre;
  logic               r_serve_dir;
  logic [1:0]         r_winner;

  logic               w_clear_scores;
  logic               w_recentre;
  logic               w_inc_l;
  logic               w_inc_r;
  logic               w_win;
  logic [3:0]         w_l_nxt_tens;
  logic [3:0]         w_l_nxt_ones;
  logic [3:0]         w_r_nxt_tens;
  logic [3:0]         w_r_nxt_ones;
  logic [6:0]         w_scorer_bin;

  bcd_counter2 u_score_l (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (w_clear_scores),
    .i_inc      (w_inc_l),
    .o_tens     (score_l_tens),
    .o_ones     (score_l_ones),
    .o_nxt_tens (w_l_nxt_tens),
    .o_nxt_ones (w_l_nxt_ones)
  );

  bcd_counter2 u_score_r (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (w_clear_scores),
    .i_inc      (w_inc_r),
    .o_tens     (score_r_tens),
    .o_ones     (score_r_ones),
    .o_nxt_tens (w_r_nxt_tens),
    .o_nxt_ones (w_r_nxt_ones)
  );

  // Win is judged in POINT on the scorer's post-increment value.
  assign w_scorer_bin = r_scorer_left ? bcd_to_bin(w_l_nxt_tens, w_l_nxt_ones)
                                      : bcd_to_bin(w_r_nxt_tens, w_r_nxt_ones);

`ifdef MATCH_WIN_BY_TWO_EN
  logic [6:0] w_other_bin;
  assign w_other_bin = r_scorer_left ? bcd_to_bin(score_r_tens, score_r_ones)
                                     : bcd_to_bin(score_l_tens, score_l_ones);
  assign w_win = ((w_scorer_bin >= c_win_score) && (w_scorer_bin >= (w_other_bin + 7'd2)))
              || (w_scorer_bin == 7'd99);
`else
  assign w_win = (w_scorer_bin == c_win_score);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    w_clear_scores = 1'b0;
    w_recentre     = 1'b0;
    w_inc_l        = 1'b0;
    w_inc_r        = 1'b0;
    case (r_state)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          w_clear_scores = 1'b1;
          w_recentre     = 1'b1;
          w_next_state   = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (frame_tick && (r_frame_cnt == c_last_cnt)) begin
          w_next_state = ST_RALLY;
        end
      end
      ST_RALLY: begin
        if (goal_left && goal_right) begin
          w_recentre   = 1'b1;
          w_next_state = ST_SERVE;
        end else if (goal_left || goal_right) begin
          w_next_state = ST_POINT;
        end
      end
      ST_POINT: begin
        w_inc_l = r_scorer_left;
        w_inc_r = !r_scorer_left;
        if (w_win) begin
          w_next_state = ST_OVER;
        end else begin
          w_recentre   = 1'b1;
          w_next_state = ST_SERVE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_cnt     <= '0;
      r_scorer_left   <= 1'b0;
      r_ball_run      <= 1'b0;
      r_ball_recentre <= 1'b0;
      r_serve_dir     <= 1'b0;
      r_winner        <= c_winner_none;
    end else begin
      r_ball_run      <= (w_next_state == ST_RALLY);
      r_ball_recentre <= w_recentre;
      if (w_recentre) begin
        r_frame_cnt <= '0;
      end else if ((r_state == ST_SERVE) && frame_tick) begin
        r_frame_cnt <= r_frame_cnt + c_cnt_w'(1);
      end
      // goal_right means the ball left on the right, so the left player scored.
      if ((r_state == ST_RALLY) && (goal_left ^ goal_right)) begin
        r_scorer_left <= goal_right;
      end
      if (r_state == ST_POINT) begin
        r_serve_dir <= r_scorer_left;
      end
      if (w_clear_scores) begin
        r_winner <= c_winner_none;
      end else if ((r_state == ST_POINT) && w_win) begin
        r_winner <= r_scorer_left ? c_winner_left : c_winner_right;
      end
    end
  end

  assign ball_run      = r_ball_run;
  assign ball_recentre = r_ball_recentre;
  assign serve_dir     = r_serve_dir;
  assign winner        = r_winner;
  assign state_o       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_match_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_match_ctrl : randomized self-checking bench for match_ctrl    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_match_ctrl;

  localparam int SERVE_FRAMES = 60;
  localparam int WIN_SCORE    = 11;
  localparam logic [2:0] S_IDLE = 3'd0, S_SERVE = 3'd1, S_RALLY = 3'd2, S_POINT = 3'd3, S_OVER = 3'd4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic       goal_left = 1'b0;
  logic       goal_right = 1'b0;
  logic       ball_run, ball_recentre, serve_dir;
  logic [3:0] score_l_tens, score_l_ones, score_r_tens, score_r_ones;
  logic [1:0] winner;
  logic [2:0] state_o;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: integer scores, serve direction and winner.
  int m_sl = 0, m_sr = 0, m_dir = 0, m_win = 0;

  match_ctrl #(.SERVE_FRAMES(SERVE_FRAMES), .WIN_SCORE(WIN_SCORE)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
    .goal_left(goal_left), .goal_right(goal_right),
    .ball_run(ball_run), .ball_recentre(ball_recentre), .serve_dir(serve_dir),
    .score_l_tens(score_l_tens), .score_l_ones(score_l_ones),
    .score_r_tens(score_r_tens), .score_r_ones(score_r_ones),
    .winner(winner), .state_o(state_o)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] bcd_exp();
    return {4'(m_sl / 10), 4'(m_sl % 10), 4'(m_sr / 10), 4'(m_sr % 10)};
  endfunction

  function automatic logic [15:0] bcd_act();
    return {score_l_tens, score_l_ones, score_r_tens, score_r_ones};
  endfunction

  function automatic bit is_win(int s, int o);
`ifdef MATCH_WIN_BY_TWO_EN
    return ((s >= WIN_SCORE) && (s - o >= 2)) || (s == 99);
`else
    return s == WIN_SCORE;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_sl = 0; m_sr = 0; m_dir = 0; m_win = 0;
  endtask

  task automatic hard_reset();
    reset = 1'b1; tick(); reset = 1'b0; tick();
    model_reset();
  endtask

  task automatic new_match();
    start = 1'b1; tick(); start = 1'b0;
    m_sl = 0; m_sr = 0; m_win = 0;
    n_cmp++;
    if (state_o !== S_SERVE || ball_recentre !== 1'b1 || winner !== 2'b00 || bcd_act() !== 16'h0) begin
      n_bad++;
      $display("FAIL new_match: state=%0d recentre=%b winner=%b scores=%h, want state=1 recentre=1 winner=00 scores=0000",
               state_o, ball_recentre, winner, bcd_act());
    end
  endtask

  // Serve period: exactly SERVE_FRAMES ticks, stray goals must be ignored.
  task automatic do_serve();
    int ticks = 0;
    int guard = 0;
    while (ticks < SERVE_FRAMES && guard < 1000) begin
      frame_tick = 1'($urandom_range(0, 1));
      goal_left  = ($urandom_range(0, 15) == 0);
      goal_right = ($urandom_range(0, 15) == 0);
      tick();
      if (frame_tick) ticks++;
      frame_tick = 1'b0; goal_left = 1'b0; goal_right = 1'b0;
      guard++;
      n_cmp++;
      if (ticks < SERVE_FRAMES) begin
        if (ball_run !== 1'b0 || state_o !== S_SERVE || bcd_act() !== bcd_exp()) begin
          n_bad++;
          $display("FAIL serve_hold: tick %0d run=%b state=%0d scores=%h, want run=0 state=1 scores=%h",
                   ticks, ball_run, state_o, bcd_act(), bcd_exp());
        end
      end else if (ball_run !== 1'b1 || state_o !== S_RALLY) begin
        n_bad++;
        $display("FAIL serve_release: run=%b state=%0d, want run=1 state=2", ball_run, state_o);
      end
    end
    if (guard >= 1000) begin
      n_cmp++; n_bad++;
      $display("FAIL serve_timeout: got %0d ticks, want %0d", ticks, SERVE_FRAMES);
    end
  endtask

  task automatic rally(int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'($urandom_range(0, 1));
      tick();
      frame_tick = 1'b0;
      n_cmp++;
      if (ball_run !== 1'b1 || state_o !== S_RALLY) begin
        n_bad++;
        $display("FAIL rally_hold: run=%b state=%0d, want run=1 state=2", ball_run, state_o);
      end
    end
  endtask

  task automatic score_point(bit left_scores);
    bit w;
    goal_right = left_scores; goal_left = !left_scores;
    tick();
    goal_right = 1'b0; goal_left = 1'b0;
    n_cmp++;
    if (state_o !== S_POINT || ball_run !== 1'b0) begin
      n_bad++;
      $display("FAIL goal_to_point: state=%0d run=%b, want state=3 run=0", state_o, ball_run);
    end
    if (left_scores) begin
      m_sl = (m_sl < 99) ? m_sl + 1 : 99; m_dir = 1; w = is_win(m_sl, m_sr);
    end else begin
      m_sr = (m_sr < 99) ? m_sr + 1 : 99; m_dir = 0; w = is_win(m_sr, m_sl);
    end
    if (w) m_win = left_scores ? 1 : 2;
    tick();
    n_cmp++;
    if (bcd_act() !== bcd_exp() || serve_dir !== 1'(m_dir)) begin
      n_bad++;
      $display("FAIL point_score: scores=%h dir=%b, want scores=%h dir=%0d", bcd_act(), serve_dir, bcd_exp(), m_dir);
    end
    n_cmp++;
    if (w ? (state_o !== S_OVER || winner !== 2'(m_win) || ball_recentre !== 1'b0)
          : (state_o !== S_SERVE || winner !== 2'b00 || ball_recentre !== 1'b1)) begin
      n_bad++;
      $display("FAIL point_next: state=%0d winner=%b recentre=%b, want state=%0d winner=%0d recentre=%0d",
               state_o, winner, ball_recentre, w ? 4 : 1, m_win, w ? 0 : 1);
    end
  endtask

  task automatic play_point(bit left_scores);
    do_serve();
    rally($urandom_range(0, 4));
    score_point(left_scores);
  endtask

  task automatic play_to(int l, int r);
    hard_reset();
    new_match();
    while (m_sl < l || m_sr < r) begin
      bit left;
      if (m_sl >= l) left = 1'b0;
      else if (m_sr >= r) left = 1'b1;
      else left = 1'($urandom_range(0, 1));
      play_point(left);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); tick();
    n_cmp++;
    if (state_o !== S_IDLE || ball_run !== 1'b0 || ball_recentre !== 1'b0 || serve_dir !== 1'b0 || winner !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_outputs: state=%0d run=%b rec=%b dir=%b win=%b, want all zero",
               state_o, ball_run, ball_recentre, serve_dir, winner);
    end
    n_cmp++;
    if (bcd_act() !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_scores: got %h want 0000", bcd_act());
    end
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) tick();
    n_cmp++;
    if (state_o !== S_IDLE || ball_run !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_hold: state=%0d run=%b, want state=0 run=0", state_o, ball_run);
    end
  endtask

  task automatic test_random_match();
    int pts = 0;
    hard_reset();
    new_match();
    while (m_win == 0 && pts < 200) begin
      if ($urandom_range(0, 7) == 0) begin
        do_serve();
        rally($urandom_range(0, 4));
        goal_left = 1'b1; goal_right = 1'b1; tick(); goal_left = 1'b0; goal_right = 1'b0;
        n_cmp++;
        if (state_o !== S_SERVE || ball_recentre !== 1'b1 || ball_run !== 1'b0 || bcd_act() !== bcd_exp()) begin
          n_bad++;
          $display("FAIL rand_let: state=%0d rec=%b run=%b scores=%h, want state=1 rec=1 run=0 scores=%h",
                   state_o, ball_recentre, ball_run, bcd_act(), bcd_exp());
        end
      end else begin
        play_point((pts > 30) ? 1'b1 : 1'($urandom_range(0, 1)));
        pts++;
      end
    end
    n_cmp++;
    if (m_win == 0 || state_o !== S_OVER) begin
      n_bad++;
      $display("FAIL rand_match_end: state=%0d model_winner=%0d, want state=4 and a winner", state_o, m_win);
    end
  endtask

  task automatic test_carry();
    play_to(9, 0);
    play_point(1'b1);
    n_cmp++;
    if (score_l_tens !== 4'd1 || score_l_ones !== 4'd0 || serve_dir !== 1'b1 || state_o !== S_SERVE) begin
      n_bad++;
      $display("FAIL bcd_carry: left=%0d:%0d dir=%b state=%0d, want 1:0 dir=1 state=1",
               score_l_tens, score_l_ones, serve_dir, state_o);
    end
  endtask

  task automatic test_let();
    play_to(3, 4);
    do_serve();
    rally(3);
    goal_left = 1'b1; goal_right = 1'b1; tick(); goal_left = 1'b0; goal_right = 1'b0;
    n_cmp++;
    if (bcd_act() !== 16'h0304 || state_o !== S_SERVE || ball_recentre !== 1'b1 || serve_dir !== 1'(m_dir)) begin
      n_bad++;
      $display("FAIL let: scores=%h state=%0d rec=%b dir=%b, want 0304 state=1 rec=1 dir=%0d",
               bcd_act(), state_o, ball_recentre, serve_dir, m_dir);
    end
    do_serve();
  endtask

  task automatic test_win();
`ifdef MATCH_WIN_BY_TWO_EN
    play_to(10, 10);
    play_point(1'b1);
    n_cmp++;
    if (state_o !== S_SERVE || winner !== 2'b00) begin
      n_bad++;
      $display("FAIL by_two_11_10: state=%0d winner=%b, want state=1 winner=00", state_o, winner);
    end
    play_point(1'b1);
`else
    play_to(10, 9);
    play_point(1'b1);
`endif
    n_cmp++;
    if (state_o !== S_OVER || winner !== 2'b01) begin
      n_bad++;
      $display("FAIL win_left: state=%0d winner=%b, want state=4 winner=01", state_o, winner);
    end
    for (int i = 0; i < 6; i++) begin
      goal_left = 1'($urandom_range(0, 1)); goal_right = 1'($urandom_range(0, 1));
      frame_tick = 1'($urandom_range(0, 1));
      tick();
      goal_left = 1'b0; goal_right = 1'b0; frame_tick = 1'b0;
      n_cmp++;
      if (state_o !== S_OVER || winner !== 2'b01 || ball_run !== 1'b0 || bcd_act() !== bcd_exp()) begin
        n_bad++;
        $display("FAIL over_hold: state=%0d winner=%b run=%b scores=%h, want 4 01 0 %h",
                 state_o, winner, ball_run, bcd_act(), bcd_exp());
      end
    end
    new_match();
  endtask

  task automatic test_async_reset();
    play_to(5, 5);
    do_serve();
    rally(5);
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (state_o !== S_IDLE || ball_run !== 1'b0 || ball_recentre !== 1'b0 || serve_dir !== 1'b0
        || winner !== 2'b00 || bcd_act() !== 16'h0) begin
      n_bad++;
      $display("FAIL async_reset_rally: state=%0d run=%b rec=%b dir=%b win=%b scores=%h, want all zero",
               state_o, ball_run, ball_recentre, serve_dir, winner, bcd_act());
    end
    tick();
    reset = 1'b0;
    model_reset();
    new_match();
    rally(0);
    for (int i = 0; i < 10; i++) begin frame_tick = 1'b1; tick(); end
    frame_tick = 1'b0;
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (state_o !== S_IDLE || bcd_act() !== 16'h0) begin
      n_bad++;
      $display("FAIL async_reset_serve: state=%0d scores=%h, want 0 0000", state_o, bcd_act());
    end
    tick();
    reset = 1'b0;
    model_reset();
    new_match();
    do_serve();
  endtask

  initial begin
    test_reset();
    new_match();
    do_serve();
    test_random_match();
    test_carry();
    test_let();
    test_win();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
